uart_tx_cfg: RTL
================

// Module: uart_tx_cfg
// PURPOSE
//  Parametrised UART transmitter: serialises DATA_BITS-wide words LSB-first with start bit,
//  optional parity bit and 1 or 2 stop bits. Valid/ready input with a one-word holding
//  buffer gives back-to-back frames with no idle gap. Sits between a byte producer and the pad.
// PARAMETERS
//  CLK_PER_BIT  87  clk cycles per serial bit (>=2); counter width $clog2(CLK_PER_BIT)
//  DATA_BITS    8   data bits per frame, 5..9
//  PARITY_MODE  0   0 = none, 1 = odd, 2 = even (3 treated as none)
//  STOP_BITS    1   stop bits per frame, 1 or 2
// PORTS
//  clk      in   1          clock, all logic on rising edge
//  rst      in   1          asynchronous, active-high reset
//  i_valid  in   1          i_data valid
//  i_data   in   DATA_BITS  word to send
//  o_ready  out  1          word accepted on edge where i_valid & o_ready
//  o_tx     out  1          serial line, registered, idles high
//  o_busy   out  1          frame in progress (START..STOP)
//  o_done   out  1          one-cycle pulse: frame's last stop bit finished
//  o_state  out  3          FSM state, debug
//  i_break  in   1          only with UART_TX_BREAK_EN
// BEHAVIOUR
//  - Reset (async): o_tx=1, o_busy=0, o_done=0, o_state=IDLE, buffer emptied, o_ready=1.
//    Reset mid-frame aborts frame; o_tx high immediately; shifter and buffer contents discarded.
//  - States: IDLE=0, START=1, DATA=2, PARITY=3, STOP=4, BREAK=5 (macro only). Other codes -> IDLE.
//  - o_ready = holding buffer empty (IDLE: buffer always empty, o_ready=1).
//  - IDLE + handshake: word loads shifter directly, next state START, o_tx<=0 on same edge
//    (o_tx low the cycle after handshake = 1-cycle latency). o_busy<=1 same edge.
//  - In START/DATA/PARITY/STOP, handshake loads holding buffer; o_ready drops next cycle.
//  - Each bit held exactly CLK_PER_BIT cycles; counter 0..CLK_PER_BIT-1, wraps to 0 at bit end.
//  - DATA: bit index 0..DATA_BITS-1, LSB first; after last -> PARITY if enabled else STOP.
//  - PARITY bit: even = ^word, odd = ~^word (total ones incl. parity odd/even).
//  - STOP: o_tx=1 for STOP_BITS*CLK_PER_BIT cycles. At end: o_done<=1 for one cycle, then
//    buffer full -> buffer into shifter, START, o_tx<=0 (no gap, o_busy stays 1);
//    buffer empty & handshake this edge -> word straight into shifter, START (no gap);
//    else -> IDLE, o_busy<=0.
//  - Frame length = (1+DATA_BITS+(PARITY_MODE?1:0)+STOP_BITS)*CLK_PER_BIT cycles.
//  - i_data changes after handshake have no effect on the frame in flight.
// CONFIGURATION
//  UART_TX_BREAK_EN defined: i_break port present. i_break sampled only in IDLE and at STOP
//   end; high there (priority over pending data) -> BREAK: o_tx=0, o_busy=1, o_ready=0 while
//   i_break high; on low -> STOP for STOP_BITS*CLK_PER_BIT (mark), no o_done pulse, then normal.
//   Buffered word is kept and sent after the break.
//  Undefined: no i_break port, no BREAK state; code 5 unreachable, falls to IDLE.
// TESTING (CLK_PER_BIT=4 unless stated)
//  1. DATA_BITS=8, PARITY_MODE=2, STOP_BITS=1, send 0xA5 -> o_tx: 0,1,0,1,0,0,1,0,1,0,1,
//     each 4 cycles (44 total); o_done one pulse; o_busy low after.
//  2. PARITY_MODE=1, send 0x07 -> parity bit 0; send 0x03 -> parity bit 1.
//  3. i_valid held, words 0x00 then 0xFF, STOP_BITS=2 -> two 44-cycle frames, no idle
//     cycle between, o_ready low from 2nd handshake until 2nd frame's START.
//  4. DATA_BITS=5, PARITY_MODE=0, send 0x1F -> 0,1,1,1,1,1,1 = 28 cycles; upper bits ignored.
//  5. Assert rst in 3rd data bit -> o_tx=1, o_busy=0, o_ready=1 same cycle; next send clean.
//  6. UART_TX_BREAK_EN: i_break high 20 cycles in IDLE -> o_tx low 20 cycles, then high
//     4 cycles, no o_done; word queued during break sent afterwards.

Source files
------------

// File: rtl/uart_tx_cfg.sv
// uart_tx_cfg: parametrised UART transmitter with a one-word holding buffer.
// Frames are start bit, DATA_BITS data bits LSB first, an optional parity bit
// and STOP_BITS stop bits. Each bit lasts CLK_PER_BIT clocks. A word taken
// while a frame is in flight is held and follows with no idle gap.
// Optional feature: define UART_TX_BREAK_EN to add i_break (line break state).
// Ports:
//   clk      rising-edge clock
//   rst      asynchronous active-high reset
//   i_valid  i_data valid; accepted when i_valid & o_ready
//   i_data   word to send (DATA_BITS wide)
//   o_ready  holding buffer empty
//   o_tx     registered serial line, idles high
//   o_busy   frame (or break) in progress
//   o_done   one-cycle pulse after the last stop bit of a frame
//   o_state  FSM state for debug
//   i_break  (UART_TX_BREAK_EN only) hold the line low while high
module uart_tx_cfg #(
    parameter int unsigned CLK_PER_BIT = 87,
    parameter int unsigned DATA_BITS   = 8,
    parameter int unsigned PARITY_MODE = 0,
    parameter int unsigned STOP_BITS   = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_valid,
    input  logic [DATA_BITS-1:0] i_data,
    output logic                 o_ready,
    output logic                 o_tx,
    output logic                 o_busy,
    output logic                 o_done,
    output logic [2:0]           o_state
`ifdef UART_TX_BREAK_EN
    ,
    input  logic                 i_break
`endif
);

    localparam int unsigned CNT_W  = $clog2(CLK_PER_BIT);
    localparam int unsigned IDX_W  = 4;
    localparam bit          PAR_EN = (PARITY_MODE == 1) || (PARITY_MODE == 2);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4,
        S_BREAK  = 3'd5
    } state_t;

    state_t               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [DATA_BITS-1:0] buf_q, buf_d;
    logic                 buf_full_q, buf_full_d;
    logic                 par_q, par_d;
    logic                 tx_q, tx_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;

    logic bit_end, last_data, last_stop, frame_end, hs, brk;
    logic enter_start, load_direct;

    function automatic logic parity_of(input logic [DATA_BITS-1:0] w);
        return (PARITY_MODE == 1) ? ~^w : ^w;
    endfunction

`ifdef UART_TX_BREAK_EN
    // Set while the post-break mark period runs, so it ends without o_done.
    logic mark_q, mark_d;
    assign brk     = i_break;
    assign o_ready = ~buf_full_q & (state_q != S_BREAK);
`else
    assign brk     = 1'b0;
    assign o_ready = ~buf_full_q;
`endif

    assign hs        = i_valid & o_ready;
    assign bit_end   = (cnt_q == CNT_W'(CLK_PER_BIT - 1));
    assign last_data = (idx_q == IDX_W'(DATA_BITS - 1));
    assign last_stop = (idx_q == IDX_W'(STOP_BITS - 1));
    assign frame_end = (state_q == S_STOP) & bit_end & last_stop;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (brk)          state_d = S_BREAK;
                else if (i_valid) state_d = S_START;
            end
            S_START:  if (bit_end) state_d = S_DATA;
            S_DATA:   if (bit_end && last_data) state_d = PAR_EN ? S_PARITY : S_STOP;
            S_PARITY: if (bit_end) state_d = S_STOP;
            S_STOP: begin
                if (frame_end) begin
                    if (brk)                         state_d = S_BREAK;
                    else if (buf_full_q || i_valid)  state_d = S_START;
                    else                             state_d = S_IDLE;
                end
            end
`ifdef UART_TX_BREAK_EN
            S_BREAK:  if (!i_break) state_d = S_STOP;
`endif
            default:  state_d = S_IDLE;
        endcase
    end

    // Datapath and registered-output next values.
    always_comb begin
        cnt_d      = '0;
        idx_d      = idx_q;
        shift_d    = shift_q;
        buf_d      = buf_q;
        buf_full_d = buf_full_q;
        par_d      = par_q;
        busy_d     = (state_d != S_IDLE);
        done_d     = frame_end;
        tx_d       = 1'b1;

        if ((state_q == S_START || state_q == S_DATA || state_q == S_PARITY ||
             state_q == S_STOP) && !bit_end)
            cnt_d = cnt_q + CNT_W'(1);

        // idx counts data bits in DATA and stop bits in STOP.
        if (state_d != state_q) idx_d = '0;
        else if (bit_end)       idx_d = idx_q + IDX_W'(1);

        if (state_q == S_DATA && bit_end) shift_d = shift_q >> 1;

        // A new frame takes the buffered word first, else the word on the bus.
        enter_start = (state_d == S_START) && (state_q != S_START);
        load_direct = enter_start && !buf_full_q;
        if (enter_start) begin
            if (buf_full_q) begin
                shift_d    = buf_q;
                par_d      = parity_of(buf_q);
                buf_full_d = 1'b0;
            end else begin
                shift_d = i_data;
                par_d   = parity_of(i_data);
            end
        end
        if (hs && !load_direct) begin
            buf_d      = i_data;
            buf_full_d = 1'b1;
        end

        case (state_d)
            S_START:  tx_d = 1'b0;
            S_DATA:   tx_d = shift_d[0];
            S_PARITY: tx_d = par_d;
            S_BREAK:  tx_d = 1'b0;
            default:  tx_d = 1'b1;
        endcase

`ifdef UART_TX_BREAK_EN
        mark_d = mark_q;
        if (state_q == S_BREAK && state_d == S_STOP) mark_d = 1'b1;
        else if (frame_end)                           mark_d = 1'b0;
        done_d = frame_end & ~mark_q;
`endif
    end

    // Datapath and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q      <= '0;
            idx_q      <= '0;
            shift_q    <= '0;
            buf_q      <= '0;
            buf_full_q <= 1'b0;
            par_q      <= 1'b0;
            tx_q       <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            shift_q    <= shift_d;
            buf_q      <= buf_d;
            buf_full_q <= buf_full_d;
            par_q      <= par_d;
            tx_q       <= tx_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

`ifdef UART_TX_BREAK_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) mark_q <= 1'b0;
        else     mark_q <= mark_d;
    end
`endif

    assign o_tx    = tx_q;
    assign o_busy  = busy_q;
    assign o_done  = done_q;
    assign o_state = state_q;

endmodule
